// File: rtl/adc_capture_buffer.sv
// adc_capture_buffer: multi-channel ADC snapshot buffer with a rolling pre-trigger window and chronological readout.
// Optional feature macro: ADC_CAPTURE_TIMESTAMP_EN (latch a free-running sample counter into TrigTime on trigger).
module adc_capture_buffer #(
    parameter int C_AdcChnls = 4,
    parameter int C_AdcBits  = 14,
    parameter int C_AddrBits = 10
) (
    input  logic                             SysClk,
    input  logic                             SysRst_n,
    input  logic                             AdcDataValid,
    input  logic [C_AdcChnls*C_AdcBits-1:0]  AdcData,
    input  logic                             Arm,
    input  logic                             ForceTrig,
    input  logic [7:0]                       TrigChnl,
    input  logic [C_AdcBits-1:0]             TrigLevel,
    input  logic                             TrigRising,
    input  logic [C_AddrBits-1:0]            PreTrig,
    output logic                             Busy,
    output logic                             Done,
    output logic [C_AddrBits-1:0]            TrigAddr,
    input  logic                             RdEn,
    input  logic [C_AddrBits-1:0]            RdAddr,
    output logic [C_AdcChnls*C_AdcBits-1:0]  RdData,
    output logic                             RdValid,
    output logic [31:0]                      TrigTime,
    output logic [2:0]                       DbgState
);

    localparam int W     = C_AdcChnls * C_AdcBits;
    localparam int DEPTH = 1 << C_AddrBits;
    localparam logic [C_AddrBits-1:0] ADDR_ZERO = '0;
    localparam logic [C_AddrBits-1:0] ADDR_ONE  = C_AddrBits'(1);
    localparam logic [C_AddrBits-1:0] ADDR_MAX  = {C_AddrBits{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_PRE       = 3'd1,
        S_WAIT_TRIG = 3'd2,
        S_POST      = 3'd3,
        S_DONE      = 3'd4
    } state_t;

    state_t state, state_nxt;

    logic [W-1:0]                mem [0:DEPTH-1];
    logic [C_AddrBits-1:0]       wr_ptr;
    logic [C_AddrBits-1:0]       pre_cnt;
    logic [C_AddrBits-1:0]       post_cnt;
    logic [C_AddrBits-1:0]       pre_trig_q;
    logic [C_AddrBits-1:0]       post_init;
    logic [C_AddrBits-1:0]       rd_phys;
    logic signed [C_AdcBits-1:0] cur_smp;
    logic signed [C_AdcBits-1:0] prev_smp;
    logic signed [C_AdcBits-1:0] trig_lvl;
    logic                        prev_vld;
    logic                        force_pend;
    logic                        lvl_hit;
    logic                        trig_fire;
    logic                        wr_en;
    logic                        capturing;

    // AdcDataValid is a one-cycle strobe with no back-pressure: every strobed
    // sample is consumed on the edge where it is high.
    assign capturing = (state == S_PRE) || (state == S_WAIT_TRIG) || (state == S_POST);
    assign wr_en     = !Arm && AdcDataValid && capturing;
    assign trig_lvl  = $signed(TrigLevel);
    assign post_init = ADDR_MAX - pre_trig_q;
    assign rd_phys   = trig_addr_q() ;

    function automatic logic [C_AddrBits-1:0] trig_addr_q();
        return TrigAddr - pre_trig_q + RdAddr;
    endfunction

    // Out-of-range channel selects fall back to channel 0.
    always_comb begin
        cur_smp = AdcData[0 +: C_AdcBits];
        for (int k = 0; k < C_AdcChnls; k++) begin
            if (TrigChnl == 8'(k)) begin
                cur_smp = AdcData[k*C_AdcBits +: C_AdcBits];
            end
        end
    end

    always_comb begin
        lvl_hit = 1'b0;
        if (prev_vld) begin
            if (TrigRising) begin
                lvl_hit = (prev_smp < trig_lvl) && (cur_smp >= trig_lvl);
            end else begin
                lvl_hit = (prev_smp >= trig_lvl) && (cur_smp < trig_lvl);
            end
        end
    end

    assign trig_fire = (state == S_WAIT_TRIG) && AdcDataValid &&
                       (lvl_hit || force_pend || ForceTrig);

    // State register
    always_ff @(posedge SysClk or negedge SysRst_n) begin
        if (!SysRst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; Arm restarts from any state and beats a same-cycle trigger.
    always_comb begin
        state_nxt = state;
        if (Arm) begin
            state_nxt = (PreTrig != ADDR_ZERO) ? S_PRE : S_WAIT_TRIG;
        end else begin
            case (state)
                S_PRE: begin
                    if (AdcDataValid && (pre_cnt == ADDR_ONE)) begin
                        state_nxt = S_WAIT_TRIG;
                    end
                end
                S_WAIT_TRIG: begin
                    if (trig_fire) begin
                        state_nxt = (post_init == ADDR_ZERO) ? S_DONE : S_POST;
                    end
                end
                S_POST: begin
                    if (AdcDataValid && (post_cnt == ADDR_ONE)) begin
                        state_nxt = S_DONE;
                    end
                end
                default: state_nxt = state;
            endcase
        end
    end

    // Output logic
    always_comb begin
        Busy     = capturing;
        Done     = (state == S_DONE);
        DbgState = state;
    end

    always_ff @(posedge SysClk or negedge SysRst_n) begin
        if (!SysRst_n) begin
            wr_ptr     <= '0;
            pre_cnt    <= '0;
            post_cnt   <= '0;
            pre_trig_q <= '0;
            prev_smp   <= '0;
            prev_vld   <= 1'b0;
            force_pend <= 1'b0;
            TrigAddr   <= '0;
        end else if (Arm) begin
            wr_ptr     <= '0;
            pre_cnt    <= PreTrig;
            pre_trig_q <= PreTrig;
            prev_vld   <= 1'b0;
            force_pend <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + ADDR_ONE;
            end
            if ((state == S_PRE) && AdcDataValid) begin
                pre_cnt <= pre_cnt - ADDR_ONE;
            end
            if (((state == S_PRE) || (state == S_WAIT_TRIG)) && AdcDataValid) begin
                prev_smp <= cur_smp;
                prev_vld <= 1'b1;
            end
            if (trig_fire) begin
                TrigAddr   <= wr_ptr;
                post_cnt   <= post_init;
                force_pend <= 1'b0;
            end else if ((state == S_WAIT_TRIG) && ForceTrig) begin
                force_pend <= 1'b1;
            end
            if ((state == S_POST) && AdcDataValid) begin
                post_cnt <= post_cnt - ADDR_ONE;
            end
        end
    end

    // Sample RAM is deliberately not reset so a record survives a reset.
    always_ff @(posedge SysClk) begin
        if (wr_en) begin
            mem[wr_ptr] <= AdcData;
        end
    end

    always_ff @(posedge SysClk or negedge SysRst_n) begin
        if (!SysRst_n) begin
            RdData  <= '0;
            RdValid <= 1'b0;
        end else begin
            RdValid <= RdEn;
            if (RdEn) begin
                RdData <= mem[rd_phys];
            end
        end
    end

`ifdef ADC_CAPTURE_TIMESTAMP_EN
    logic [31:0] ts_cnt;
    logic [31:0] trig_time;

    // The counter value before this sample's increment equals the number of earlier strobes.
    always_ff @(posedge SysClk or negedge SysRst_n) begin
        if (!SysRst_n) begin
            ts_cnt    <= '0;
            trig_time <= '0;
        end else begin
            if (AdcDataValid) begin
                ts_cnt <= ts_cnt + 32'd1;
            end
            if (trig_fire && !Arm) begin
                trig_time <= ts_cnt;
            end
        end
    end

    assign TrigTime = trig_time;
`else
    assign TrigTime = 32'd0;
`endif

endmodule

// File: tb/tb_adc_capture_buffer.sv
// tb_adc_capture_buffer: directed bench for adc_capture_buffer (depth 16, 4 x 14-bit channels).
// Honours ADC_CAPTURE_TIMESTAMP_EN for the expected TrigTime.
module tb_adc_capture_buffer;
  localparam int CH = 4;
  localparam int BITS = 14;
  localparam int AB = 4;
  localparam int W = CH * BITS;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_PRE  = 3'd1;
  localparam logic [2:0] ST_WAIT = 3'd2;
  localparam logic [2:0] ST_POST = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  logic          clk;
  logic          rst_n;
  logic          adc_valid;
  logic [W-1:0]  adc_data;
  logic          arm;
  logic          force_trig;
  logic [7:0]    trig_chnl;
  logic [BITS-1:0] trig_level;
  logic          trig_rising;
  logic [AB-1:0] pre_trig;
  logic          busy;
  logic          done;
  logic [AB-1:0] trig_addr;
  logic          rd_en;
  logic [AB-1:0] rd_addr;
  logic [W-1:0]  rd_data;
  logic          rd_valid;
  logic [31:0]   trig_time;
  logic [2:0]    dbg_state;

  int n_checks = 0;
  int n_fail = 0;
  logic [W-1:0] exp_q[$];
  int sine[8] = '{0, 60, 90, 60, 0, -60, -90, -60};

  adc_capture_buffer #(
    .C_AdcChnls(CH),
    .C_AdcBits(BITS),
    .C_AddrBits(AB)
  ) dut (
    .SysClk(clk),
    .SysRst_n(rst_n),
    .AdcDataValid(adc_valid),
    .AdcData(adc_data),
    .Arm(arm),
    .ForceTrig(force_trig),
    .TrigChnl(trig_chnl),
    .TrigLevel(trig_level),
    .TrigRising(trig_rising),
    .PreTrig(pre_trig),
    .Busy(busy),
    .Done(done),
    .TrigAddr(trig_addr),
    .RdEn(rd_en),
    .RdAddr(rd_addr),
    .RdData(rd_data),
    .RdValid(rd_valid),
    .TrigTime(trig_time),
    .DbgState(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] pack(input int c0, input int c1, input int c2, input int c3);
    pack = {c3[BITS-1:0], c2[BITS-1:0], c1[BITS-1:0], c0[BITS-1:0]};
  endfunction

  function automatic logic [W-1:0] d_a(input int k);
    d_a = pack(1000 + k, 2000 + k, -1 - k, k);
  endfunction

  function automatic logic [W-1:0] d_b(input int i);
    d_b = pack(10 * i, 3 * i, -i, 7);
  endfunction

  function automatic logic [W-1:0] d_d(input int i);
    d_d = pack((i % 2) ? -1000 : 1000, (i % 2) ? -2000 : 2000, sine[i % 8], -1000);
  endfunction

  // driver tasks: entered at a negedge, return at the next negedge
  task automatic smp(input logic [W-1:0] d);
    adc_valid = 1'b1;
    adc_data = d;
    @(negedge clk);
    adc_valid = 1'b0;
  endtask

  task automatic do_arm(input int pre);
    pre_trig = AB'(pre);
    arm = 1'b1;
    @(negedge clk);
    arm = 1'b0;
  endtask

  task automatic do_force();
    force_trig = 1'b1;
    @(negedge clk);
    force_trig = 1'b0;
  endtask

  task automatic do_read(input int a, output logic [W-1:0] d, output logic v);
    rd_en = 1'b1;
    rd_addr = AB'(a);
    @(negedge clk);
    rd_en = 1'b0;
    d = rd_data;
    v = rd_valid;
  endtask

  initial begin
    logic [W-1:0] rd;
    logic rv;
    logic [W-1:0] exp_w;

    rst_n = 1'b0;
    adc_valid = 1'b0;
    adc_data = '0;
    arm = 1'b0;
    force_trig = 1'b0;
    trig_chnl = 8'd0;
    trig_level = '0;
    trig_rising = 1'b1;
    pre_trig = '0;
    rd_en = 1'b0;
    rd_addr = '0;

    repeat (2) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_trig_addr", 64'(trig_addr), 64'd0);
    check("rst_rd_data", 64'(rd_data), 64'd0);
    check("rst_rd_valid", 64'(rd_valid), 64'd0);
    check("rst_trig_time", 64'(trig_time), 64'd0);
    check("rst_state", 64'(dbg_state), 64'(ST_IDLE));
    rst_n = 1'b1;
    @(negedge clk);

    // Forced trigger, PreTrig=0, with 37 strobes seen before the trigger sample
    for (int i = 0; i < 37; i++) smp('0);
    check("a_idle_state", 64'(dbg_state), 64'(ST_IDLE));
    trig_chnl = 8'd0;
    trig_level = 14'h1fff;
    trig_rising = 1'b1;
    do_arm(0);
    check("a_wait_state", 64'(dbg_state), 64'(ST_WAIT));
    check("a_busy", 64'(busy), 64'd1);
    do_force();
    repeat (5) @(negedge clk);
    check("a_force_pending_state", 64'(dbg_state), 64'(ST_WAIT));
    smp(d_a(0));
    check("a_post_state", 64'(dbg_state), 64'(ST_POST));
    check("a_trig_addr", 64'(trig_addr), 64'd0);
`ifdef ADC_CAPTURE_TIMESTAMP_EN
    check("a_trig_time", 64'(trig_time), 64'd37);
`else
    check("a_trig_time", 64'(trig_time), 64'd0);
`endif
    for (int k = 1; k < 15; k++) smp(d_a(k));
    check("a_done_before_last", 64'(done), 64'd0);
    smp(d_a(15));
    check("a_done", 64'(done), 64'd1);
    check("a_busy_done", 64'(busy), 64'd0);
    smp(pack(7, 7, 7, 7));
    smp(pack(7, 7, 7, 7));
    do_read(0, rd, rv);
    check("a_rd0", 64'(rd), 64'(d_a(0)));
    do_read(7, rd, rv);
    check("a_rd7", 64'(rd), 64'(d_a(7)));
    do_read(15, rd, rv);
    check("a_rd15", 64'(rd), 64'(d_a(15)));

    // Ramp 0,10,20..., rising at 100, PreTrig=4
    trig_level = 14'd100;
    trig_rising = 1'b1;
    trig_chnl = 8'd0;
    do_arm(4);
    check("b_pre_state", 64'(dbg_state), 64'(ST_PRE));
    check("b_done_cleared", 64'(done), 64'd0);
    for (int i = 0; i < 22; i++) begin
      smp(d_b(i));
      if (i == 3) check("b_wait_after_pre", 64'(dbg_state), 64'(ST_WAIT));
      if (i == 9) check("b_no_trig_at_90", 64'(dbg_state), 64'(ST_WAIT));
      if (i == 10) begin
        check("b_post_state", 64'(dbg_state), 64'(ST_POST));
        check("b_trig_addr", 64'(trig_addr), 64'd10);
      end
      if (i == 20) check("b_done_early", 64'(done), 64'd0);
    end
    check("b_done", 64'(done), 64'd1);
    for (int k = 0; k < 16; k++) exp_q.push_back(d_b(6 + k));
    for (int k = 0; k < 16; k++) begin
      do_read(k, rd, rv);
      exp_w = exp_q.pop_front();
      check($sformatf("b_rd%0d", k), 64'(rd), 64'(exp_w));
      check($sformatf("b_rv%0d", k), 64'(rv), 64'd1);
    end
    @(negedge clk);
    check("b_rv_pulse", 64'(rd_valid), 64'd0);
    check("b_rd_hold", 64'(rd_data), 64'(d_b(21)));

    // ForceTrig in DONE is dropped; PrevVld gating; Arm aborts POST
    do_force();
    do_arm(0);
    smp(pack(500, 0, 0, 0));
    check("c_no_stale_force", 64'(dbg_state), 64'(ST_WAIT));
    smp(pack(600, 0, 0, 0));
    check("c_above_no_trig", 64'(dbg_state), 64'(ST_WAIT));
    smp(pack(50, 0, 0, 0));
    check("c_drop_no_trig", 64'(dbg_state), 64'(ST_WAIT));
    smp(pack(150, 0, 0, 0));
    check("c_cross_state", 64'(dbg_state), 64'(ST_POST));
    check("c_trig_addr", 64'(trig_addr), 64'd3);
    do_arm(2);
    check("c_abort_state", 64'(dbg_state), 64'(ST_PRE));
    check("c_abort_busy", 64'(busy), 64'd1);
    check("c_abort_done", 64'(done), 64'd0);
    smp(pack(0, 0, 0, 0));
    smp(pack(0, 0, 0, 0));
    check("c_rewait_state", 64'(dbg_state), 64'(ST_WAIT));

    // Falling at -50 on channel 2 sine, other channels swing across the level
    trig_chnl = 8'd2;
    trig_level = 14'h3fce;
    trig_rising = 1'b0;
    do_arm(3);
    for (int i = 0; i < 18; i++) begin
      smp(d_d(i));
      if (i == 4) check("d_other_chnl_ignored", 64'(dbg_state), 64'(ST_WAIT));
      if (i == 5) begin
        check("d_post_state", 64'(dbg_state), 64'(ST_POST));
        check("d_trig_addr", 64'(trig_addr), 64'd5);
      end
      if (i == 16) check("d_done_early", 64'(done), 64'd0);
    end
    check("d_done", 64'(done), 64'd1);
    do_read(3, rd, rv);
    check("d_rd_trig_sample", 64'(rd), 64'(d_d(5)));
    check("d_rd_trig_ch2", 64'(rd[2*BITS +: BITS]), 64'(14'h3fc4));
    do_read(0, rd, rv);
    check("d_rd0", 64'(rd), 64'(d_d(2)));
    do_read(15, rd, rv);
    check("d_rd15", 64'(rd), 64'(d_d(17)));

    // Out-of-range TrigChnl falls back to channel 0
    trig_chnl = 8'd9;
    trig_level = 14'd100;
    trig_rising = 1'b1;
    do_arm(0);
    smp(pack(50, 0, 500, 0));
    check("e_wait_state", 64'(dbg_state), 64'(ST_WAIT));
    smp(pack(150, 0, 500, 0));
    check("e_ch0_trig", 64'(dbg_state), 64'(ST_POST));
    check("e_trig_addr", 64'(trig_addr), 64'd1);

    // Reset mid-capture: immediate return to IDLE, RAM retained
    rst_n = 1'b0;
    #1;
    check("f_rst_state", 64'(dbg_state), 64'(ST_IDLE));
    check("f_rst_busy", 64'(busy), 64'd0);
    check("f_rst_trig_addr", 64'(trig_addr), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_read(0, rd, rv);
    check("f_ram_kept0", 64'(rd), 64'(pack(50, 0, 500, 0)));
    do_read(1, rd, rv);
    check("f_ram_kept1", 64'(rd), 64'(pack(150, 0, 500, 0)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/adc_capture_buffer.md
# adc_capture_buffer

Parametrised multi-channel ADC snapshot buffer with pre-trigger history. It sits between the ADC344x deserialiser outputs (AdcDataValid, AdcDataChN) and the PS readout logic on the sample clock domain. It arms on request, keeps a rolling pre-trigger window, fires on a level crossing of a selected channel or on a forced trigger, then freezes one full-depth record for random-access readout in chronological order.

## Interface
Parameters:
- C_AdcChnls, 4, channels packed on AdcData
- C_AdcBits, 14, bits per sample, two's complement
- C_AddrBits, 10, buffer depth D = 2**C_AddrBits records

Ports (all synchronous to SysClk except SysRst_n):
- SysClk  in  1  sample clock
- SysRst_n  in  1  asynchronous, active-low reset
- AdcDataValid  in  1  sample strobe
- AdcData  in  C_AdcChnls*C_AdcBits  channel k at bits [k*C_AdcBits +: C_AdcBits]
- Arm  in  1  single-cycle pulse; start or restart a capture
- ForceTrig  in  1  single-cycle pulse; software trigger
- TrigChnl  in  8  trigger source channel; values >= C_AdcChnls select channel 0
- TrigLevel  in  C_AdcBits  signed threshold
- TrigRising  in  1  1 = rising crossing, 0 = falling crossing
- PreTrig  in  C_AddrBits  pre-trigger sample count; sampled on Arm
- Busy  out  1  capture in progress
- Done  out  1  record frozen and readable
- TrigAddr  out  C_AddrBits  physical address of the trigger sample
- RdEn  in  1  read request
- RdAddr  in  C_AddrBits  logical index; 0 = oldest sample in the record
- RdData  out  C_AdcChnls*C_AdcBits  read data
- RdValid  out  1  RdData valid
- TrigTime  out  32  sample timestamp of the trigger (see Configuration)

## Operation
- Dual-port RAM, D x (C_AdcChnls*C_AdcBits), is not reset. WrPtr wraps modulo D.
- FSM states: IDLE, PRE, WAIT_TRIG, POST, DONE. Reset state is IDLE.
  - IDLE/DONE --Arm--> PRE if PreTrig > 0, else WAIT_TRIG.
    - On Arm: latch PreTrig as PreCnt; clear WrPtr, Done, and PrevVld.
  - PRE: each valid sample is written and PreCnt decrements. When the last pre sample is written, go to WAIT_TRIG.
  - WAIT_TRIG: each valid sample is written (rolling window). A trigger fires on a valid sample when one of these holds:
    - rising: PrevVld && prev < TrigLevel && cur >= TrigLevel
    - falling: PrevVld && prev >= TrigLevel && cur < TrigLevel
    - ForceTrig was seen while in WAIT_TRIG; it is held pending until the next valid sample.
  - On trigger: write the sample, TrigAddr <= WrPtr, PostCnt <= D - PreTrig - 1, go to POST. If PostCnt = 0, go directly to DONE.
  - POST: each valid sample is written and PostCnt decrements. When it reaches 0 on a write, go to DONE.
  - DONE: no writes. Done = 1.
- Comparison is signed, C_AdcBits wide, and uses only the selected channel. The prev register updates on every valid sample in PRE and WAIT_TRIG. PrevVld is set after the first such sample.
- Arm in any state aborts the current capture and restarts it. Arm takes priority over a trigger in the same cycle.
- ForceTrig outside WAIT_TRIG is ignored and not held pending.
- Readout: physical address = (TrigAddr - PreTrig_latched + RdAddr) mod D. Reads are legal in any state; contents are only defined in DONE.
- Busy = state in {PRE, WAIT_TRIG, POST}.

## Timing
- Reset values: Busy 0, Done 0, TrigAddr 0, RdData 0, RdValid 0, TrigTime 0.
- Write latency: a sample with AdcDataValid high at edge n is in RAM at edge n+1.
- Trigger decision is combinational on the current sample. TrigAddr updates at the same edge the sample is written.
- Done and Busy change on the edge that writes the final POST sample.
- Read latency is 1 cycle: RdEn at edge n gives RdData/RdValid at edge n+1. RdValid is a 1-cycle pulse. RdData holds its value between reads.
- Reset asserted mid-capture returns the block to IDLE immediately; RAM contents are retained.

## Configuration
- ADC_CAPTURE_TIMESTAMP_EN defined: a free-running 32-bit counter increments on every AdcDataValid and wraps. It is latched into TrigTime on trigger.
- Not defined: the counter is removed and TrigTime is tied to 0.

## Test plan
- C_AddrBits=4, PreTrig=4, rising, level 100, ramp 0,10,20,... -> trigger on sample 100; after readout, RdAddr 0..15 = 60,70,...,210; TrigAddr = 10.
- Falling trigger on channel 2, level -50, sine input -> the first logical sample after PreTrig satisfies the crossing; channels 0, 1 and 3 are unaffected by the trigger logic.
- PreTrig=0, ForceTrig pulsed in WAIT_TRIG with AdcDataValid low for 5 cycles -> trigger fires on the next valid sample; Done after exactly D valid samples.
- Arm re-asserted during POST -> Busy stays 1, state returns to PRE, and the old record is not reported as Done.
- Level already exceeded on the first sample after Arm -> no trigger until a genuine crossing (PrevVld gating).
- With ADC_CAPTURE_TIMESTAMP_EN: 37 valid samples before trigger -> TrigTime = 37; without the macro -> TrigTime = 0.
